// File: rtl/branch_redirect_unit.sv
// -----------------------------------------------------------------------------
// branch_redirect_unit
//
// Consumes the ID-stage compare result and resolves control transfers
// (conditional branches, JAL, JALR). When a transfer is taken and its target
// is word aligned, a redirect request is raised towards IF with a valid/ready
// handshake. Once IF accepts, the IF/ID contents are squashed for
// FLUSH_CYCLES cycles. ID is held stalled for as long as a redirect is in
// flight. A taken transfer to a target that is not 4-byte aligned does not
// redirect; it raises a one-cycle misaligned-target exception instead.
//
// Parameters
//   WIDTH        address/data width
//   FLUSH_CYCLES cycles flush_if is held after the redirect handshake (>=1)
//   CNT_W        width of the completed-redirect counter
//
// Ports
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   id_valid     in   ID holds a valid instruction
//   id_branch    in   conditional branch, taken when cmp_flag is set
//   id_jal       in   JAL, always taken
//   id_jalr      in   JALR, always taken
//   id_pc        in   PC of the ID instruction
//   id_imm       in   sign-extended immediate
//   id_rs1       in   forwarded rs1 value, JALR base
//   cmp_flag     in   compare result, already selected per funct3
//   redir_ready  in   IF accepts the redirect
//   redir_valid  out  redirect request to IF
//   redir_pc     out  redirect target, stable while redir_valid is high
//   flush_if     out  squash IF/ID register contents
//   id_stall     out  freeze the ID stage
//   misalign_exc out  one-cycle pulse, taken target not 4-byte aligned
//   taken_cnt    out  number of completed redirects, wraps
// -----------------------------------------------------------------------------
module branch_redirect_unit #(
  parameter int WIDTH        = 32,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic             id_branch,
  input  logic             id_jal,
  input  logic             id_jalr,
  input  logic [WIDTH-1:0] id_pc,
  input  logic [WIDTH-1:0] id_imm,
  input  logic [WIDTH-1:0] id_rs1,
  input  logic             cmp_flag,
  input  logic             redir_ready,
  output logic             redir_valid,
  output logic [WIDTH-1:0] redir_pc,
  output logic             flush_if,
  output logic             id_stall,
  output logic             misalign_exc,
  output logic [CNT_W-1:0] taken_cnt
);

  // Flush counter only needs to hold FLUSH_CYCLES down to 1.
  localparam int FC_W = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES + 1);
  localparam logic [FC_W-1:0] FC_LOAD = FC_W'(FLUSH_CYCLES);
  localparam logic [FC_W-1:0] FC_ONE  = FC_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [FC_W-1:0]  fcnt, fcnt_nxt;
  logic [WIDTH-1:0] pc_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             rv_nxt;
  logic             fl_nxt;
  logic             exc_nxt;

  logic             take;
  logic [WIDTH-1:0] target;

  // JALR forms its target from rs1 and clears bit 0; every other taken
  // transfer is PC-relative. The adds wrap modulo 2^WIDTH.
  function automatic logic [WIDTH-1:0] calc_target(
    input logic             jalr,
    input logic [WIDTH-1:0] pc,
    input logic [WIDTH-1:0] imm,
    input logic [WIDTH-1:0] rs1
  );
    logic [WIDTH-1:0] sum;
    if (jalr) begin
      sum    = rs1 + imm;
      sum[0] = 1'b0;
    end else begin
      sum = pc + imm;
    end
    return sum;
  endfunction

  function automatic logic is_aligned(input logic [WIDTH-1:0] t);
    return (t[1:0] == 2'b00);
  endfunction

  // The type flags are not one-hot guaranteed; the OR decides taken-ness and
  // jalr wins target selection, which gives jalr > jal > branch priority.
  assign take   = id_valid & ((id_branch & cmp_flag) | id_jal | id_jalr);
  assign target = calc_target(id_jalr, id_pc, id_imm, id_rs1);

  // Stall follows the registered state only, so it never depends on inputs
  // of the current cycle.
  assign id_stall = (state != ST_IDLE);

  always_comb begin
    state_nxt = state;
    fcnt_nxt  = fcnt;
    pc_nxt    = redir_pc;
    cnt_nxt   = taken_cnt;
    rv_nxt    = redir_valid;
    fl_nxt    = flush_if;
    exc_nxt   = 1'b0;

    case (state)
      ST_IDLE: begin
        rv_nxt = 1'b0;
        fl_nxt = 1'b0;
        if (take) begin
          if (is_aligned(target)) begin
            pc_nxt    = target;
            rv_nxt    = 1'b1;
            state_nxt = ST_REQ;
          end else begin
            exc_nxt = 1'b1;
          end
        end
      end

      // Request is held, target frozen, until IF accepts.
      ST_REQ: begin
        if (redir_valid && redir_ready) begin
          rv_nxt    = 1'b0;
          cnt_nxt   = taken_cnt + CNT_W'(1);
          fcnt_nxt  = FC_LOAD;
          fl_nxt    = 1'b1;
          state_nxt = ST_FLUSH;
        end
      end

      ST_FLUSH: begin
        if (fcnt == FC_ONE) begin
          fcnt_nxt  = '0;
          fl_nxt    = 1'b0;
          state_nxt = ST_IDLE;
        end else begin
          fcnt_nxt = fcnt - FC_ONE;
        end
      end

      default: begin
        rv_nxt    = 1'b0;
        fl_nxt    = 1'b0;
        fcnt_nxt  = '0;
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      fcnt         <= '0;
      redir_valid  <= 1'b0;
      redir_pc     <= '0;
      flush_if     <= 1'b0;
      misalign_exc <= 1'b0;
      taken_cnt    <= '0;
    end else begin
      state        <= state_nxt;
      fcnt         <= fcnt_nxt;
      redir_valid  <= rv_nxt;
      redir_pc     <= pc_nxt;
      flush_if     <= fl_nxt;
      misalign_exc <= exc_nxt;
      taken_cnt    <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_branch_redirect_unit.sv
module tb_branch_redirect_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid, id_branch, id_jal, id_jalr, cmp_flag, redir_ready;
  logic [31:0] id_pc, id_imm, id_rs1;

  // Instance a: single flush cycle, narrow counter so wrap is exercised.
  logic        rv_a, fl_a, st_a, exc_a;
  logic [31:0] pc_a;
  logic [3:0]  cnt_a;
  // Instance b: three flush cycles, default counter width.
  logic        rv_b, fl_b, st_b, exc_b;
  logic [31:0] pc_b;
  logic [15:0] cnt_b;

  always #5 clk = ~clk;

  branch_redirect_unit #(.WIDTH(32), .FLUSH_CYCLES(1), .CNT_W(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_branch(id_branch),
    .id_jal(id_jal), .id_jalr(id_jalr), .id_pc(id_pc), .id_imm(id_imm),
    .id_rs1(id_rs1), .cmp_flag(cmp_flag), .redir_ready(redir_ready),
    .redir_valid(rv_a), .redir_pc(pc_a), .flush_if(fl_a), .id_stall(st_a),
    .misalign_exc(exc_a), .taken_cnt(cnt_a)
  );

  branch_redirect_unit #(.WIDTH(32), .FLUSH_CYCLES(3), .CNT_W(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_branch(id_branch),
    .id_jal(id_jal), .id_jalr(id_jalr), .id_pc(id_pc), .id_imm(id_imm),
    .id_rs1(id_rs1), .cmp_flag(cmp_flag), .redir_ready(redir_ready),
    .redir_valid(rv_b), .redir_pc(pc_b), .flush_if(fl_b), .id_stall(st_b),
    .misalign_exc(exc_b), .taken_cnt(cnt_b)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: per instance, an outstanding redirect (flag + target),
  // the number of squash cycles still owed, the exception pulse and the count.
  int          m_fc[2] = '{1, 3};
  int          m_cw[2] = '{4, 16};
  bit          m_req[2];
  logic [31:0] m_pc[2];
  int          m_fl[2];
  bit          m_exc[2];
  longint      m_cnt[2];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_req[i] = 0; m_pc[i] = '0; m_fl[i] = 0; m_exc[i] = 0; m_cnt[i] = 0;
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      bit          tk;
      logic [31:0] tg;
      m_exc[i] = 0;
      if (m_req[i]) begin
        if (redir_ready) begin
          m_req[i] = 0;
          m_cnt[i] = (m_cnt[i] + 1) % (64'd1 << m_cw[i]);
          m_fl[i]  = m_fc[i];
        end
      end else if (m_fl[i] > 0) begin
        m_fl[i]--;
      end else begin
        tk = id_valid && ((id_branch && cmp_flag) || id_jal || id_jalr);
        if (id_jalr) tg = (id_rs1 + id_imm) & 32'hFFFF_FFFE;
        else         tg = id_pc + id_imm;
        if (tk) begin
          if (tg % 4 == 0) begin
            m_req[i] = 1;
            m_pc[i]  = tg;
          end else begin
            m_exc[i] = 1;
          end
        end
      end
    end
  endtask

  function automatic bit busy();
    return m_req[0] || m_req[1] || (m_fl[0] > 0) || (m_fl[1] > 0);
  endfunction

  task automatic check_all();
    chk("a.redir_valid",  rv_a,  m_req[0]);
    chk("a.redir_pc",     pc_a,  m_pc[0]);
    chk("a.flush_if",     fl_a,  m_fl[0] > 0);
    chk("a.id_stall",     st_a,  m_req[0] || m_fl[0] > 0);
    chk("a.misalign_exc", exc_a, m_exc[0]);
    chk("a.taken_cnt",    cnt_a, m_cnt[0]);
    chk("b.redir_valid",  rv_b,  m_req[1]);
    chk("b.redir_pc",     pc_b,  m_pc[1]);
    chk("b.flush_if",     fl_b,  m_fl[1] > 0);
    chk("b.id_stall",     st_b,  m_req[1] || m_fl[1] > 0);
    chk("b.misalign_exc", exc_b, m_exc[1]);
    chk("b.taken_cnt",    cnt_b, m_cnt[1]);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic idle_inputs();
    id_valid = 0; id_branch = 0; id_jal = 0; id_jalr = 0; cmp_flag = 0;
    id_pc = '0; id_imm = '0; id_rs1 = '0; redir_ready = 1;
  endtask

  task automatic settle();
    idle_inputs();
    for (int k = 0; k < 20 && busy(); k++) cycle();
    chk("settle_idle", busy(), 0);
  endtask

  task automatic async_reset_pulse();
    #1 rst_n = 0;
    #1;
    model_reset();
    check_all();
    #1 rst_n = 1;
  endtask

  initial begin
    int nflush;
    idle_inputs();
    rst_n = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    rst_n = 1;

    // Taken BEQ with IF ready immediately
    id_valid = 1; id_branch = 1; cmp_flag = 1; id_pc = 32'h100; id_imm = 32'h20;
    cycle();
    chk("beq_valid", rv_a, 1);
    chk("beq_pc", pc_a, 32'h120);
    idle_inputs();
    cycle();
    chk("beq_flush", fl_a, 1);
    cycle();
    chk("beq_cnt", cnt_a, 1);
    settle();

    // Not-taken BNE: no cost at all
    id_valid = 1; id_branch = 1; cmp_flag = 0; id_pc = 32'h200; id_imm = 32'h40;
    cycle();
    chk("bne_valid", rv_a, 0);
    chk("bne_stall", st_a, 0);
    idle_inputs();

    // JALR with IF back-pressure for five cycles
    id_valid = 1; id_jalr = 1; id_rs1 = 32'h203; id_imm = 32'h1; redir_ready = 0;
    cycle();
    id_valid = 0; id_jalr = 0;
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("jalr_hold_pc", pc_a, 32'h204);
      chk("jalr_stall", st_a, 1);
    end
    redir_ready = 1;
    cycle();
    chk("jalr_flush", fl_a, 1);
    settle();

    // JAL to a misaligned target
    id_valid = 1; id_jal = 1; id_pc = 32'h100; id_imm = 32'h2;
    cycle();
    chk("jal_exc", exc_a, 1);
    chk("jal_novalid", rv_a, 0);
    idle_inputs();
    cycle();
    chk("jal_exc_pulse", exc_a, 0);
    settle();

    // Wrapping target, three-cycle flush on instance b
    id_valid = 1; id_branch = 1; cmp_flag = 1; id_pc = 32'hFFFF_FFF0; id_imm = 32'h20;
    cycle();
    chk("wrap_pc", pc_b, 32'h10);
    idle_inputs();
    nflush = 0;
    for (int k = 0; k < 6; k++) begin
      cycle();
      if (fl_b) nflush++;
    end
    chk("wrap_flush_len", nflush, 3);
    settle();

    // Asynchronous reset while a request is outstanding
    id_valid = 1; id_jal = 1; id_pc = 32'h300; id_imm = 32'h10; redir_ready = 0;
    cycle();
    chk("rst_pre_valid", rv_a, 1);
    async_reset_pulse();
    chk("rst_valid", rv_a, 0);
    chk("rst_stall", st_b, 0);
    id_valid = 1; id_jal = 0; id_branch = 1; cmp_flag = 1; id_pc = 32'h400; id_imm = 32'h8;
    redir_ready = 1;
    cycle();
    chk("post_rst_pc", pc_a, 32'h408);
    settle();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      id_valid    = ($urandom_range(0, 9) < 7);
      id_branch   = $urandom_range(0, 1);
      id_jal      = ($urandom_range(0, 3) == 0);
      id_jalr     = ($urandom_range(0, 3) == 0);
      cmp_flag    = $urandom_range(0, 1);
      id_pc       = $urandom & 32'hFFFF_FFFC;
      id_imm      = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 7) == 0) id_imm[1:0] = 2'($urandom_range(1, 3));
      id_rs1      = $urandom;
      redir_ready = ($urandom_range(0, 9) < 6);
      if ($urandom_range(0, 299) == 0) async_reset_pulse();
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
